rgb_led_arbiter: RTL



---
 rtl/rgb_pkg.sv | 26 ++
 rtl/rgb_led_arbiter_if.sv | 47 ++++
 rtl/rgb_led_arbiter_rr_select.sv | 57 +++++
 rtl/rgb_led_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pkg
// Shared types and constants for the on-board RGB LED path.
//   color_t      : 3-bit colour, packed {red, green, blue}
//   RED..OFF     : named colours for pattern generators and the arbiter
//   arb_state_t  : arbiter state encoding (IDLE, GRANT, GAP)
// -----------------------------------------------------------------------------
package rgb_pkg;

    typedef logic [2:0] color_t;

    localparam color_t RED     = 3'b100;
    localparam color_t YELLOW  = 3'b110;
    localparam color_t GREEN   = 3'b010;
    localparam color_t CYAN    = 3'b011;
    localparam color_t BLUE    = 3'b001;
    localparam color_t MAGENTA = 3'b101;
    localparam color_t OFF     = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rgb_led_arbiter_if.sv
// -----------------------------------------------------------------------------
// rgb_led_arbiter_if
// Bundle between the pattern sources and the LED arbiter.
//   req    : per-requester request level
//   color  : per-requester colour {r,g,b}
//   gnt    : one-hot grant back to the sources
//   red/green/blue : LED pin drives
//   busy   : arbiter is in a grant slot or a blanking gap
// Modports:
//   master : pattern-source side (drives req/color, observes the rest)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface rgb_led_arbiter_if
    import rgb_pkg::*;
#(
    parameter int N_REQ = 3
) ();

    logic   [N_REQ-1:0] req;
    color_t [N_REQ-1:0] color;
    logic   [N_REQ-1:0] gnt;
    logic               red;
    logic               green;
    logic               blue;
    logic               busy;

    modport master (
        output req,
        output color,
        input  gnt,
        input  red,
        input  green,
        input  blue,
        input  busy
    );

    modport slave (
        input  req,
        input  color,
        output gnt,
        output red,
        output green,
        output blue,
        output busy
    );

endinterface

// File: rtl/rgb_led_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker, usable for any shared resource.
// Searches i_req starting at (i_ptr+1) mod N_REQ and returns the first
// requesting index.
//   i_req    : request vector
//   i_ptr    : index of the last winner
//   o_winner : selected index (0 when nothing requests)
//   o_valid  : at least one request is set
// -----------------------------------------------------------------------------
module rr_select #(
    parameter int N_REQ = 3,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [IW-1:0]    o_winner,
    output logic             o_valid
);

    // One extra bit holds ptr + N_REQ without overflow before the wrap.
    logic [IW:0]     w_sum  [N_REQ];
    logic [IW:0]     w_wrap [N_REQ];
    logic [IW-1:0]   w_cand [N_REQ];
    logic [N_REQ-1:0] w_hit;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            // Candidate for search offset gi+1, wrapped by subtraction
            // instead of a divider.
            assign w_sum[gi]  = {1'b0, i_ptr} + (IW+1)'(gi + 1);
            assign w_wrap[gi] = (w_sum[gi] >= (IW+1)'(N_REQ))
                              ? w_sum[gi] - (IW+1)'(N_REQ)
                              : w_sum[gi];
            // A corrupted pointer on a non-power-of-2 N_REQ could still
            // leave an out-of-range value; clamp so nothing beyond
            // N_REQ-1 is ever indexed.
            assign w_cand[gi] = (w_wrap[gi] < (IW+1)'(N_REQ))
                              ? w_wrap[gi][IW-1:0]
                              : '0;
            assign w_hit[gi]  = i_req[w_cand[gi]];
        end
    endgenerate

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_valid  = 1'b1;
                o_winner = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/rgb_led_arbiter.sv
// -----------------------------------------------------------------------------
// rgb_led_arbiter
// Shares the single RGB LED between N_REQ pattern sources. Grants round-robin
// for a dwell slot of at most DWELL_CYCLES, optionally followed by a
// GAP_CYCLES LED-off blanking gap so the handover is visible.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of rgb_led_arbiter_if
//          (req/color in; gnt/red/green/blue/busy out, all registered)
// -----------------------------------------------------------------------------
module rgb_led_arbiter
    import rgb_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int DWELL_CYCLES = 2000000,
    parameter int GAP_CYCLES   = 240000
) (
    input  logic              clk,
    input  logic              rst,
    rgb_led_arbiter_if.slave  bus
);

    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CMAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit            HAS_GAP    = (GAP_CYCLES > 0);

    // State and registered outputs
    arb_state_t        r_state;
    logic [CW-1:0]     r_count;
    logic [IW-1:0]     r_ptr;     // last winner; equals the owner while in GRANT
    logic [N_REQ-1:0]  r_gnt;
    color_t            r_rgb;
    logic              r_busy;

    // Next-state and decode
    arb_state_t        w_state_next;
    logic [CW-1:0]     w_count_next;
    logic [IW-1:0]     w_ptr_next;
    logic              w_entry;
    logic [N_REQ-1:0]  w_gnt_next;
    color_t            w_rgb_next;
    logic              w_busy_next;
    logic [IW-1:0]     w_winner;
    logic              w_valid;
    logic              w_owner_req;
    logic              w_slot_end;
    logic              w_gap_end;

    rr_select #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_select (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    assign w_owner_req = bus.req[r_ptr];
    // Early release and dwell expiry take the same exit.
    assign w_slot_end  = !w_owner_req || (r_count == DWELL_LAST);
    assign w_gap_end   = (r_count == GAP_LAST);

    // -------------------------------------------------------------------------
    // State register (also holds the registered output stage)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_ptr   <= IW'(N_REQ - 1);   // requester 0 wins first
            r_gnt   <= '0;
            r_rgb   <= OFF;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_ptr   <= w_ptr_next;
            r_gnt   <= w_gnt_next;
            r_rgb   <= w_rgb_next;
            r_busy  <= w_busy_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_entry      = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_next = GRANT;
                    w_ptr_next   = w_winner;
                    w_entry      = 1'b1;
                end
            end

            GRANT: begin
                if (w_slot_end) begin
                    w_entry = 1'b1;
                    if (HAS_GAP) begin
                        w_state_next = GAP;
                    end else if (w_valid) begin
                        // Back-to-back hand-over; may re-grant the same
                        // requester when it is the only one asking.
                        w_state_next = GRANT;
                        w_ptr_next   = w_winner;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end

            GAP: begin
                if (w_gap_end) begin
                    w_entry = 1'b1;
                    if (w_valid) begin
                        w_state_next = GRANT;
                        w_ptr_next   = w_winner;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
                w_entry      = 1'b1;
            end
        endcase

        // Counter restarts on every state entry and idles at zero.
        if (w_entry || (r_state == IDLE)) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + CW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: decoded from the next state so gnt, LED and busy all
    // change on the same edge as the state itself.
    // -------------------------------------------------------------------------
    always_comb begin
        w_gnt_next  = '0;
        w_rgb_next  = OFF;
        w_busy_next = (w_state_next != IDLE);
        if (w_state_next == GRANT) begin
            w_gnt_next[w_ptr_next] = 1'b1;
            // Colour is resampled every edge, so live changes track with
            // one cycle of latency.
            w_rgb_next = bus.color[w_ptr_next];
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.red   = r_rgb[2];
    assign bus.green = r_rgb[1];
    assign bus.blue  = r_rgb[0];
    assign bus.busy  = r_busy;

endmodule
